three_phase_nco: RTL
====================

# three_phase_nco

Three-phase numerically controlled oscillator that drives the three read ports of the sine look-up ROM and collects its samples. A 32-bit phase accumulator advances by a frequency tuning word (FTW). Addresses for phases 0°, 120° and 240° are issued every enabled cycle. The returned ROM words are re-aligned into a three-sample output with a single valid strobe. The block sits between the control logic that supplies the FTW and the DAC/PWM stage that consumes the samples.

## Interface
- PHASE_W, 32, accumulator width
- ADDR_W, 15, ROM address width; address = top ADDR_W bits of phase
- DATA_W, 16, ROM data / sample width
- LUT_LATENCY, 1, ROM read latency in cycles (registered ROM)
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  advance accumulator and issue one address triple this cycle
- phase_clr  in  1  synchronous phase clear to 0
- ftw_in  in  PHASE_W  new tuning word
- ftw_valid  in  1  ftw_in offered
- ftw_ready  out  1  block can accept a tuning word
- lut_addr1 / lut_addr2 / lut_addr3  out  ADDR_W  ROM addresses for 0°, 120°, 240°
- lut_data1 / lut_data2 / lut_data3  in  DATA_W  ROM read data
- sample1 / sample2 / sample3  out  DATA_W  aligned output samples
- sample_valid  out  1  one-cycle strobe per enabled cycle

## Operation
- Phase update: on an enable cycle, acc <= acc + ftw_cur, modulo 2^PHASE_W.
  - wrap = carry-out of that 33-bit add.
- Address generation, registered:
  - lut_addrK <= (acc_next + OFF_K)[PHASE_W-1 -: ADDR_W].
  - OFF_1 = 0, OFF_2 = 0x55555555, OFF_3 = 0xAAAAAAAA.
  - Sums wrap modulo 2^PHASE_W.
- Valid pipeline: a shift register of depth LUT_LATENCY+1 carries enable.
  - When its tail is 1, sampleK <= lut_dataK and sample_valid = 1.
  - Otherwise samples hold their value and sample_valid = 0.
- FTW handshake FSM, states IDLE and PENDING:
  - IDLE: ftw_ready=1. ftw_valid in this state captures ftw_in into ftw_pend and moves to PENDING.
  - PENDING: ftw_ready=0. Move ftw_pend to ftw_cur and return to IDLE on the first of:
    - an enable cycle with wrap=1, for a phase-continuous switch at zero crossing;
    - any cycle where ftw_cur==0 or enable=0;
    - phase_clr=1.
  - The new word takes effect on the following accumulator update.
- phase_clr: acc <= 0. The valid pipeline is not flushed; in-flight samples still emerge.
- Boundary rules:
  - phase_clr with enable in the same cycle: clear wins, acc=0 and no advance. Addresses issued are 0x0000 / 0x2AAA / 0x5555 with a valid token.
  - ftw_valid in IDLE in the same cycle as a wrap: the word is captured only. It is applied at the next qualifying event, not at this wrap.
  - ftw_valid while PENDING: ignored, since ftw_ready=0.
  - ftw_cur==0: acc frozen and addresses constant, but samples still strobe on enable.
  - Reset mid-operation: the pending word is discarded and the pipeline is cleared.

## Timing
- Reset values:
  - acc = 0, ftw_cur = 0, ftw_pend = 0, state IDLE.
  - All lut_addrK = 0, all sampleK = 0, sample_valid = 0.
  - ftw_ready = 0 while rst_n=0, and 1 in the first cycle after release.
- Address latency: the enable in cycle n produces new lut_addrK in cycle n+1.
- Sample latency: sample_valid rises in cycle n+1+LUT_LATENCY, which is n+2 by default, carrying ROM data for the cycle-n+1 addresses.
- Throughput: one sample triple per clock under continuous enable.
- FTW apply latency:
  - At most one cycle when idle-enabled or ftw_cur==0.
  - Otherwise bounded by one accumulator period.

## Structure
- Package nco_pkg holds:
  - PHASE_W, ADDR_W, DATA_W;
  - OFF_120 = 32'h5555_5555 and OFF_240 = 32'hAAAA_AAAA;
  - the FTW FSM state enum {FTW_IDLE, FTW_PENDING}.
- Sub-module phase_accumulator: acc register, FTW FSM, wrap detection and handshake.
- The top level contains:
  - the three offset adders and address registers;
  - the valid delay line;
  - the sample capture registers.

## Test plan
- Reset then ftw=0x0002_0000 accepted, enable held high:
  - lut_addr1 = 0x0001, 0x0002, 0x0003, …;
  - lut_addr2 = lut_addr1 + 0x2AAA mod 2^15;
  - lut_addr3 = lut_addr1 + 0x5555 mod 2^15.
- ROM model returning data = address:
  - sample_valid first high 2 cycles after the first enable;
  - sample1 equals the address issued one cycle earlier.
- Enable toggled 1,0,1,1: sample_valid pattern is 1,0,1,1, delayed by 2 cycles, and the accumulator does not advance on the 0 cycle.
- Running with ftw=0x4000_0000, offer ftw=0x8000_0000 mid-period:
  - ftw_ready drops;
  - the new step first appears after the accumulator returns to 0;
  - ftw_ready returns to 1 in the cycle after the wrap.
- phase_clr asserted together with enable while acc = 0x1234_5678: the next addresses are 0x0000 / 0x2AAA / 0x5555.
- rst_n pulsed low for one cycle during PENDING, with valid tokens in flight:
  - all outputs return to 0 and sample_valid stays 0;
  - ftw_ready=1 after release;
  - the old pending word is never applied.

Source files
------------

// File: rtl/three_phase_nco_pkg.sv
// Shared widths, phase offsets and FTW handshake state type for the three-phase NCO.
package nco_pkg;
    localparam int PHASE_W     = 32;
    localparam int ADDR_W      = 15;
    localparam int DATA_W      = 16;
    localparam int LUT_LATENCY = 1;

    localparam logic [PHASE_W-1:0] OFF_120 = 32'h5555_5555;
    localparam logic [PHASE_W-1:0] OFF_240 = 32'hAAAA_AAAA;

    typedef enum logic {FTW_IDLE, FTW_PENDING} ftw_state_t;

    // Offset the phase modulo 2^PHASE_W and keep the top ADDR_W bits as the ROM address.
    function automatic logic [ADDR_W-1:0] phase_to_addr(input logic [PHASE_W-1:0] phase,
                                                        input logic [PHASE_W-1:0] offset);
        logic [PHASE_W-1:0] sum;
        sum = phase + offset;
        return sum[PHASE_W-1 -: ADDR_W];
    endfunction
endpackage

// File: rtl/three_phase_nco_if.sv
// FTW handshake, ROM read ports and sample outputs of the NCO; master is the NCO side.
interface three_phase_nco_if;
    import nco_pkg::*;

    logic [PHASE_W-1:0] ftw_in;
    logic               ftw_valid;
    logic               ftw_ready;
    logic [ADDR_W-1:0]  lut_addr1;
    logic [ADDR_W-1:0]  lut_addr2;
    logic [ADDR_W-1:0]  lut_addr3;
    logic [DATA_W-1:0]  lut_data1;
    logic [DATA_W-1:0]  lut_data2;
    logic [DATA_W-1:0]  lut_data3;
    logic [DATA_W-1:0]  sample1;
    logic [DATA_W-1:0]  sample2;
    logic [DATA_W-1:0]  sample3;
    logic               sample_valid;

    modport master (
        input  ftw_in, ftw_valid, lut_data1, lut_data2, lut_data3,
        output ftw_ready, lut_addr1, lut_addr2, lut_addr3,
               sample1, sample2, sample3, sample_valid
    );

    modport slave (
        output ftw_in, ftw_valid, lut_data1, lut_data2, lut_data3,
        input  ftw_ready, lut_addr1, lut_addr2, lut_addr3,
               sample1, sample2, sample3, sample_valid
    );
endinterface

// File: rtl/three_phase_nco_phase_accumulator.sv
// Phase accumulator with a two-state tuning-word handshake that swaps the FTW at a phase wrap.
module phase_accumulator
    import nco_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               phase_clr,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    output logic [PHASE_W-1:0] acc_next
);
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] ftw_cur;
    logic [PHASE_W-1:0] ftw_pend;
    logic [PHASE_W:0]   sum;
    logic               wrap;
    logic               capture;
    logic               apply;
    ftw_state_t         state;
    ftw_state_t         state_next;

    assign sum  = {1'b0, acc} + {1'b0, ftw_cur};
    assign wrap = enable && !phase_clr && sum[PHASE_W];

    always_comb begin
        acc_next = acc;
        if (phase_clr) begin
            acc_next = '0;
        end else if (enable) begin
            acc_next = sum[PHASE_W-1:0];
        end
    end

    // A pending word waits for a zero crossing unless the oscillator is idle or frozen.
    always_comb begin
        state_next = state;
        ftw_ready  = 1'b0;
        capture    = 1'b0;
        apply      = 1'b0;
        case (state)
            FTW_IDLE: begin
                ftw_ready = rst_n;
                if (ftw_valid) begin
                    capture    = 1'b1;
                    state_next = FTW_PENDING;
                end
            end
            FTW_PENDING: begin
                if (wrap || ftw_cur == '0 || !enable || phase_clr) begin
                    apply      = 1'b1;
                    state_next = FTW_IDLE;
                end
            end
            default: state_next = FTW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            ftw_cur  <= '0;
            ftw_pend <= '0;
            state    <= FTW_IDLE;
        end else begin
            acc   <= acc_next;
            state <= state_next;
            if (capture) ftw_pend <= ftw_in;
            if (apply)   ftw_cur  <= ftw_pend;
        end
    end
endmodule

// File: rtl/three_phase_nco.sv
// Three-phase NCO: issues 0/120/240 degree ROM addresses and re-aligns the returned samples.
module three_phase_nco
    import nco_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               phase_clr,
    three_phase_nco_if.master  bus
);
    logic [PHASE_W-1:0]   acc_next;
    logic                 ftw_ready;
    logic [ADDR_W-1:0]    addr1, addr2, addr3;
    logic [LUT_LATENCY:0] valid_pipe;
    logic                 tail;
    logic [DATA_W-1:0]    held1, held2, held3;

    phase_accumulator u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .phase_clr (phase_clr),
        .ftw_in    (bus.ftw_in),
        .ftw_valid (bus.ftw_valid),
        .ftw_ready (ftw_ready),
        .acc_next  (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr1      <= '0;
            addr2      <= '0;
            addr3      <= '0;
            valid_pipe <= '0;
            held1      <= '0;
            held2      <= '0;
            held3      <= '0;
        end else begin
            addr1      <= phase_to_addr(acc_next, '0);
            addr2      <= phase_to_addr(acc_next, OFF_120);
            addr3      <= phase_to_addr(acc_next, OFF_240);
            valid_pipe <= {valid_pipe[LUT_LATENCY-1:0], enable};
            if (tail) begin
                held1 <= bus.lut_data1;
                held2 <= bus.lut_data2;
                held3 <= bus.lut_data3;
            end
        end
    end

    // ROM data arrives in the same cycle as the token tail, so it is passed straight through.
    assign tail             = valid_pipe[LUT_LATENCY];
    assign bus.ftw_ready    = ftw_ready;
    assign bus.lut_addr1    = addr1;
    assign bus.lut_addr2    = addr2;
    assign bus.lut_addr3    = addr3;
    assign bus.sample_valid = tail;
    assign bus.sample1      = tail ? bus.lut_data1 : held1;
    assign bus.sample2      = tail ? bus.lut_data2 : held2;
    assign bus.sample3      = tail ? bus.lut_data3 : held3;
endmodule
